// File: rtl/seq_mul8_pkg.sv
// ---------------------------------------------------------------------------
// seq_mul8_pkg
// Shared definitions for the sequential 8x8 nibble-scheduled multiplier.
//   - state_e     : controller states (IDLE=0, MUL=1, DONE=2)
//   - STEP_*      : step numbers of the four nibble partial products
//   - ACC_W       : accumulator / result width
//   - step_shift  : left shift that aligns a partial product for its step
//   - align_product : widens an 8-bit partial product to ACC_W and aligns it
// ---------------------------------------------------------------------------
package seq_mul8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Step order: al*bl, ah*bl, al*bh, ah*bh
  localparam logic [1:0] STEP_LL = 2'd0;
  localparam logic [1:0] STEP_HL = 2'd1;
  localparam logic [1:0] STEP_LH = 2'd2;
  localparam logic [1:0] STEP_HH = 2'd3;

  localparam int ACC_W = 16;

  // The two cross products both sit at nibble offset 1
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    logic [3:0] sh;
    case (step)
      STEP_LL: sh = 4'd0;
      STEP_HL: sh = 4'd4;
      STEP_LH: sh = 4'd4;
      default: sh = 4'd8;
    endcase
    return sh;
  endfunction

  // Widen before shifting so the high partial product is never truncated
  function automatic logic [ACC_W-1:0] align_product(input logic [7:0] p,
                                                     input logic [1:0] step);
    logic [ACC_W-1:0] wide;
    wide = {{(ACC_W-8){1'b0}}, p};
    return wide << step_shift(step);
  endfunction

endpackage

// File: rtl/mul4x4_exact.sv
// ---------------------------------------------------------------------------
// mul4x4_exact
// Purely combinational unsigned 4x4 -> 8 multiplier, shared by all steps.
//   x : input  [3:0]  nibble operand
//   y : input  [3:0]  nibble operand
//   p : output [7:0]  x * y (max 225, always fits)
// ---------------------------------------------------------------------------
module mul4x4_exact (
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [7:0] p
);

  // Zero-extend both operands so the product is computed at full 8-bit width
  assign p = {4'b0000, x} * {4'b0000, y};

endmodule

// File: rtl/seq_mul8_sched.sv
// ---------------------------------------------------------------------------
// seq_mul8_sched
// Sequential 8x8 unsigned multiplier that reuses one 4x4 multiplier over the
// four nibble partial products, one product per clock. An optional
// approximate mode skips the low x low product (r[3:0] forced to zero) and
// finishes one cycle sooner.
//
// Parameters:
//   APPROX_EN : 1 = per-request approx input honoured, 0 = always exact
// Ports:
//   clk       : input        rising-edge clock
//   rst       : input        synchronous active-high reset
//   in_valid  : input        operand request
//   in_ready  : output       high in IDLE, request accepted on valid&&ready
//   a, b      : input  [7:0] unsigned operands
//   approx    : input        per-request approximate mode
//   out_valid : output       high in DONE, result available on r
//   out_ready : input        consumer accepts result
//   r         : output [15:0] accumulator (meaningful when out_valid)
//   busy      : output       high whenever not in IDLE
// ---------------------------------------------------------------------------
module seq_mul8_sched
  import seq_mul8_pkg::*;
#(
  parameter int unsigned APPROX_EN = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic        approx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] r,
  output logic        busy
);

  state_e             state_q, state_d;
  logic [1:0]         step_q, step_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [7:0]         a_q, a_d;
  logic [7:0]         b_q, b_d;
  logic               approx_q, approx_d;

  logic               approx_eff;
  logic [3:0]         mul_x;
  logic [3:0]         mul_y;
  logic [7:0]         mul_p;
  logic [ACC_W-1:0]   aligned_p;
  logic               add_en;

  assign approx_eff = approx && (APPROX_EN != 0);

  // Step bit 0 selects the high nibble of a, step bit 1 the high nibble of b,
  // which yields the order al*bl, ah*bl, al*bh, ah*bh.
  assign mul_x = step_q[0] ? a_q[7:4] : a_q[3:0];
  assign mul_y = step_q[1] ? b_q[7:4] : b_q[3:0];

  mul4x4_exact u_mul (
    .x (mul_x),
    .y (mul_y),
    .p (mul_p)
  );

  assign aligned_p = align_product(mul_p, step_q);

  // Approximate requests start at STEP_HL, so this guard only matters if the
  // step counter were ever at STEP_LL in approximate mode.
  assign add_en = !(approx_q && (step_q == STEP_LL));

  // Outputs decode the registered state only; no handshake input feeds them.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q != ST_IDLE);
  assign r         = acc_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          approx_d = approx_eff;
          acc_d    = '0;
          step_d   = approx_eff ? STEP_HL : STEP_LL;
          state_d  = ST_MUL;
        end
      end

      ST_MUL: begin
        acc_d  = acc_q + (add_en ? aligned_p : {ACC_W{1'b0}});
        step_d = step_q + 2'd1;
        if (step_q == STEP_HH) begin
          step_d  = STEP_LL;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        // Result held here; a new request can only be taken once back in IDLE
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        step_d  = STEP_LL;
      end
    endcase
  end

  // Reset wins over every handshake in the same cycle and clears all state
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      step_q   <= STEP_LL;
      acc_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
    end
  end

endmodule

// File: tb/tb_seq_mul8_sched.sv
// ---------------------------------------------------------------------------
// tb_seq_mul8_sched
// Bench for seq_mul8_sched. Two instances share all inputs: inst 0 with
// APPROX_EN=1 and inst 1 with APPROX_EN=0. A transaction-level model tracks,
// per instance, whether a request is outstanding, how many cycles remain
// until its result appears, and the arithmetic result it must show.
// ---------------------------------------------------------------------------
module tb_seq_mul8_sched;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        approx;
  logic        out_ready;
  logic [1:0]  in_ready_s;
  logic [1:0]  out_valid_s;
  logic [1:0]  busy_s;
  logic [15:0] r_s [2];

  int vec_count  = 0;
  int miscompares = 0;

  seq_mul8_sched #(.APPROX_EN(1)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s[0]),
    .a         (a),
    .b         (b),
    .approx    (approx),
    .out_valid (out_valid_s[0]),
    .out_ready (out_ready),
    .r         (r_s[0]),
    .busy      (busy_s[0])
  );

  seq_mul8_sched #(.APPROX_EN(0)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready_s[1]),
    .a         (a),
    .b         (b),
    .approx    (approx),
    .out_valid (out_valid_s[1]),
    .out_ready (out_ready),
    .r         (r_s[1]),
    .busy      (busy_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, reports a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: latency count plus arithmetic result per instance
  bit          armed = 1'b0;
  bit          m_busy [2];
  bit          m_done [2];
  int          m_cnt  [2];
  logic [15:0] m_res  [2];

  always @(posedge clk) begin
    if (rst) begin
      armed = 1'b1;
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_cnt[i]  = 0;
        m_res[i]  = 16'h0000;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (!m_busy[i]) begin
          if (in_valid) begin
            int  full;
            bit  eff;
            eff  = approx && (i == 0);
            full = int'(a) * int'(b);
            if (eff) full = full - int'(a[3:0]) * int'(b[3:0]);
            m_res[i]  = 16'(full);
            m_cnt[i]  = eff ? 3 : 4;
            m_busy[i] = 1'b1;
            m_done[i] = 1'b0;
          end
        end else if (!m_done[i]) begin
          m_cnt[i]--;
          if (m_cnt[i] == 0) m_done[i] = 1'b1;
        end else if (out_ready) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b0;
        end
      end
    end
  end

  // Compare DUT outputs to the model on every cycle, away from the edge
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        checkOutput($sformatf("mdl%0d_in_ready", i), 32'(in_ready_s[i]), 32'(!m_busy[i]));
        checkOutput($sformatf("mdl%0d_out_valid", i), 32'(out_valid_s[i]), 32'(m_done[i]));
        checkOutput($sformatf("mdl%0d_busy", i), 32'(busy_s[i]), 32'(m_busy[i]));
        if (m_done[i])
          checkOutput($sformatf("mdl%0d_r", i), 32'(r_s[i]), 32'(m_res[i]));
      end
    end
  end

  // Issue one request with both instances idle, then measure each
  // instance's latency and result with out_ready high.
  task automatic applyStimulus(input string name, input logic [7:0] ta,
                               input logic [7:0] tb_b, input logic tap,
                               input logic [15:0] exp0, input int lat0_exp,
                               input logic [15:0] exp1, input int lat1_exp);
    int          lat0;
    int          lat1;
    logic [15:0] cap0;
    logic [15:0] cap1;
    lat0 = 0; lat1 = 0; cap0 = 16'h0; cap1 = 16'h0;
    in_valid = 1'b1; a = ta; b = tb_b; approx = tap;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk); #1;
      if (out_valid_s[0] && lat0 == 0) begin lat0 = e; cap0 = r_s[0]; end
      if (out_valid_s[1] && lat1 == 0) begin lat1 = e; cap1 = r_s[1]; end
    end
    checkOutput({name, "_lat0"}, 32'(lat0), 32'(lat0_exp));
    checkOutput({name, "_r0"},   32'(cap0), 32'(exp0));
    checkOutput({name, "_lat1"}, 32'(lat1), 32'(lat1_exp));
    checkOutput({name, "_r1"},   32'(cap1), 32'(exp1));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1; in_valid = 1'b0; a = 8'h00; b = 8'h00; approx = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("rst%0d_in_ready", i), 32'(in_ready_s[i]), 32'd1);
      checkOutput($sformatf("rst%0d_out_valid", i), 32'(out_valid_s[i]), 32'd0);
      checkOutput($sformatf("rst%0d_busy", i), 32'(busy_s[i]), 32'd0);
      checkOutput($sformatf("rst%0d_r", i), 32'(r_s[i]), 32'd0);
    end

    // Corner operands, exact and approximate
    applyStimulus("ff_exact",  8'hFF, 8'hFF, 1'b0, 16'hFE01, 4, 16'hFE01, 4);
    applyStimulus("ff_approx", 8'hFF, 8'hFF, 1'b1, 16'hFD20, 3, 16'hFE01, 4);
    applyStimulus("x12_exact", 8'h12, 8'h34, 1'b0, 16'h03A8, 4, 16'h03A8, 4);
    applyStimulus("x12_approx",8'h12, 8'h34, 1'b1, 16'h03A0, 3, 16'h03A8, 4);

    // Consumer stall: result held in DONE, operand changes ignored
    out_ready = 1'b0;
    in_valid = 1'b1; a = 8'h5A; b = 8'h3C; approx = 1'b0;
    @(posedge clk); #1;
    a = 8'h77; b = 8'h99; approx = 1'b1;
    waited = 0;
    while (!out_valid_s[0] && waited < 8) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("stall_lat", 32'(waited), 32'd4);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      checkOutput("stall_out_valid", 32'(out_valid_s[0]), 32'd1);
      checkOutput("stall_r", 32'(r_s[0]), 32'h1518);
      checkOutput("stall_in_ready", 32'(in_ready_s[0]), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("release_in_ready", 32'(in_ready_s[0]), 32'd1);
    checkOutput("release_out_valid", 32'(out_valid_s[0]), 32'd0);
    checkOutput("release_busy", 32'(busy_s[0]), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;

    // Reset while step 2 of an exact 0xFF*0xFF is pending
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF; approx = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("abort_out_valid", 32'(out_valid_s[0]), 32'd0);
    checkOutput("abort_r", 32'(r_s[0]), 32'd0);
    checkOutput("abort_in_ready", 32'(in_ready_s[0]), 32'd1);
    applyStimulus("zero_mul", 8'h00, 8'hAB, 1'b0, 16'h0000, 4, 16'h0000, 4);

    // Back-to-back requests with operands changing every cycle
    for (int k = 0; k < 120; k++) begin
      in_valid  = 1'b1;
      a         = 8'($urandom);
      b         = 8'($urandom);
      approx    = (k >= 60) ? 1'($urandom) : 1'b0;
      out_ready = (k >= 60) ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
